// File: rtl/qpu_pkg.sv
// -----------------------------------------------------------------------------
// qpu_pkg
// Shared definitions for the QPU program path: instruction width, program
// memory geometry, opcode constants, the loader state encoding and the single
// definition of the instruction field layout used by both the loader
// (encoding) and the instruction decoder (decoding).
// -----------------------------------------------------------------------------
package qpu_pkg;

    localparam int IW    = 7;   // instruction word width
    localparam int DEPTH = 16;  // program memory entries
    localparam int AW    = 4;   // program memory address width

    // Opcode field values. OPC_NOP with zero qubit fields encodes to 7'b0,
    // which is what the fetch port returns outside the loaded program.
    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_X    = 3'b001;
    localparam logic [2:0] OPC_Z    = 3'b010;
    localparam logic [2:0] OPC_H    = 3'b011;
    localparam logic [2:0] OPC_CNOT = 3'b100;
    localparam logic [2:0] OPC_CZ   = 3'b101;
    localparam logic [2:0] OPC_SWAP = 3'b110;
    localparam logic [2:0] OPC_MEAS = 3'b111;

    // Program loader states.
    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,  // nothing loaded
        LD_LOAD  = 2'd1,  // accepting instruction beats
        LD_READY = 2'd2   // complete program resident
    } ld_state_t;

    // Instruction layout: opcode in [6:4], qubit1 in [3:2], qubit2 in [1:0].
    function automatic logic [IW-1:0] encode_instr(
        input logic [2:0] opcode,
        input logic [1:0] q1,
        input logic [1:0] q2
    );
        return {opcode, q1, q2};
    endfunction

endpackage

// File: rtl/qpu_prog_mem.sv
// -----------------------------------------------------------------------------
// qpu_prog_mem
// DEPTH x IW program memory with one synchronous write port and one
// asynchronous (combinational) read port, so the PC sees a ROM-like fetch.
//
// Ports:
//   clk        in   clock
//   i_wr_en    in   write enable, sampled on rising clk
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   i_rd_addr  in   read address
//   o_rd_data  out  contents at i_rd_addr (combinational)
// -----------------------------------------------------------------------------
module qpu_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 7
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);

    logic [IW-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; it maps onto plain storage, and the
    // loader's prog_len masking keeps stale contents from ever being fetched.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/qpu_program_loader.sv
// -----------------------------------------------------------------------------
// qpu_program_loader
// Write-side replacement for the fixed QPU program ROM. Instruction fields
// arrive on a valid/ready stream, are encoded into IW-bit words and written
// into a DEPTH-entry program memory. The PC fetches combinationally; any
// address at or beyond prog_len reads as NOP (0). core_run is only high once
// a complete program has been loaded.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   load_start   in   pulse: begin / restart a program load
//   in_valid     in   instruction beat valid
//   in_ready     out  beat accepted when in_valid && in_ready
//   in_opcode    in   opcode field
//   in_q1        in   qubit1 field
//   in_q2        in   qubit2 field
//   in_last      in   final instruction of the program
//   load_done    out  one-cycle pulse after a load completes
//   overflow     out  sticky: program truncated at DEPTH entries
//   prog_len     out  number of valid instructions, 0..DEPTH
//   core_run     out  high while a complete program is resident
//   fetch_addr   in   PC address
//   fetch_instr  out  instruction at fetch_addr, 0 outside the program
// -----------------------------------------------------------------------------
module qpu_program_loader
    import qpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = qpu_pkg::IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opcode,
    input  logic [1:0]    in_q1,
    input  logic [1:0]    in_q2,
    input  logic          in_last,
    output logic          load_done,
    output logic          overflow,
    output logic [AW:0]   prog_len,
    output logic          core_run,
    input  logic [AW-1:0] fetch_addr,
    output logic [IW-1:0] fetch_instr
);

    ld_state_t     r_state;
    ld_state_t     w_state_nxt;

    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_prog_len;
    logic          r_overflow;
    logic          r_load_done;

    logic          w_accept;
    logic          w_at_end;
    logic          w_complete;
    logic          w_in_range;
    logic [IW-1:0] w_wr_data;
    logic [IW-1:0] w_rd_data;

    // A beat at the last address closes the load whether or not it is marked
    // in_last; without in_last it is a truncation.
    assign w_accept   = in_valid && in_ready;
    assign w_at_end   = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_complete = w_accept && (in_last || w_at_end);
    assign w_wr_data  = encode_instr(in_opcode, in_q1, in_q2);

    // ---------------------------------------------------------------- state
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // load_start wins over everything: it (re)starts a load from any state.
    // in_ready is low in that cycle, so it never competes with a completion.
    always_comb begin
        // NOTE: default assignment first, so no path leaves the signal
        // unassigned and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            LD_IDLE: begin
                if (load_start) w_state_nxt = LD_LOAD;
            end
            LD_LOAD: begin
                if (load_start)      w_state_nxt = LD_LOAD;
                else if (w_complete) w_state_nxt = LD_READY;
            end
            LD_READY: begin
                if (load_start) w_state_nxt = LD_LOAD;
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready = 1'b0;
        core_run = 1'b0;
        case (r_state)
            LD_LOAD:  in_ready = !load_start;
            LD_READY: core_run = 1'b1;
            default: begin
                in_ready = 1'b0;
                core_run = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    // Entering LOAD (from any state) clears pointer, length and overflow, so
    // the old program is invisible from the edge that sees load_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_prog_len  <= '0;
            r_overflow  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_complete;
            if (load_start) begin
                r_wr_ptr   <= '0;
                r_prog_len <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_prog_len <= r_prog_len + (AW+1)'(1);
                if (w_at_end && !in_last) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    qpu_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_prog_mem (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (fetch_addr),
        .o_rd_data (w_rd_data)
    );

    // Out-of-program addresses read as NOP so PC wrap-around is harmless.
    assign w_in_range  = ({1'b0, fetch_addr} < r_prog_len);
    assign fetch_instr = w_in_range ? w_rd_data : '0;

    assign prog_len  = r_prog_len;
    assign overflow  = r_overflow;
    assign load_done = r_load_done;

endmodule

// File: tb/tb_qpu_program_loader.sv
// -----------------------------------------------------------------------------
// tb_qpu_program_loader
// Self-checking bench: a behavioural model of the loader predicts handshake
// and status outputs each cycle, and every beat the model expects to be
// accepted pushes its (address, encoded instruction) onto a scoreboard that is
// drained through the fetch port once a load has completed.
// -----------------------------------------------------------------------------
module tb_qpu_program_loader;
    import qpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [1:0] in_q1;
    logic [1:0] in_q2;
    logic       in_last;
    logic       load_done;
    logic       overflow;
    logic [4:0] prog_len;
    logic       core_run;
    logic [3:0] fetch_addr;
    logic [6:0] fetch_instr;

    always #5 clk = ~clk;

    qpu_program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_q1       (in_q1),
        .in_q2       (in_q2),
        .in_last     (in_last),
        .load_done   (load_done),
        .overflow    (overflow),
        .prog_len    (prog_len),
        .core_run    (core_run),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr)
    );

    typedef struct {
        logic [3:0] addr;
        logic [6:0] instr;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;   // load_done pulses seen on the DUT

    // Reference model state.
    ld_state_t m_state;
    int        m_ptr;
    int        m_len;
    logic      m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = LD_IDLE;
        m_ptr   = 0;
        m_len   = 0;
        m_ovf   = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle of stimulus. Called 1 time unit after a rising edge;
    // returns 1 time unit after the next rising edge.
    task automatic cycle(input logic ls, input logic v, input logic [2:0] op,
                         input logic [1:0] a, input logic [1:0] b, input logic last);
        logic exp_rdy;
        logic acc;
        logic done;
        load_start = ls;
        in_valid   = v;
        in_opcode  = op;
        in_q1      = a;
        in_q2      = b;
        in_last    = last;
        #1;
        exp_rdy = (m_state == LD_LOAD) && !ls;
        check("in_ready", in_ready, exp_rdy);
        acc  = v && exp_rdy;
        done = 1'b0;
        if (ls) begin
            m_state = LD_LOAD;
            m_ptr   = 0;
            m_len   = 0;
            m_ovf   = 1'b0;
            sb_q.delete();
        end else if (acc) begin
            sb_q.push_back('{addr: 4'(m_ptr), instr: {op, a, b}});
            if (last || m_ptr == 15) begin
                done    = 1'b1;
                m_state = LD_READY;
                if (!last) m_ovf = 1'b1;
            end
            m_ptr++;
            m_len++;
        end
        @(posedge clk);
        #1;
        if (load_done) n_done++;
        check("load_done", load_done, done);
        check("core_run", core_run, m_state == LD_READY);
        check("prog_len", prog_len, m_len);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic beat(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic last);
        cycle(1'b0, 1'b1, op, a, b, last);
    endtask

    // Pop every scoreboard entry through the fetch port, then confirm every
    // address beyond the model's program length reads as NOP.
    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            fetch_addr = e.addr;
            #1;
            check("fetch", fetch_instr, e.instr);
        end
        for (int a = m_len; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            check("fetch_nop", fetch_instr, 7'h00);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_expect(input logic [3:0] addr, input logic [6:0] exp);
        fetch_addr = addr;
        #1;
        check("fetch_const", fetch_instr, exp);
    endtask

    initial begin
        int done_base;

        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_q1      = '0;
        in_q2      = '0;
        in_last    = 1'b0;
        fetch_addr = '0;
        model_reset();

        // ---- reset state
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_core_run", core_run, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_prog_len", prog_len, 5'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drain();
        idle(2);

        // ---- 3-beat program
        done_base = n_done;
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        beat(3'b010, 2'b01, 2'b10, 1'b0);
        beat(3'b001, 2'b00, 2'b11, 1'b0);
        beat(3'b100, 2'b11, 2'b00, 1'b1);
        idle(2);
        check("three_done_cnt", n_done - done_base, 1);
        fetch_expect(4'd0, 7'h26);
        fetch_expect(4'd1, 7'h13);
        fetch_expect(4'd2, 7'h4C);
        fetch_expect(4'd3, 7'h00);
        drain();

        // ---- 17 beats without in_last: truncated at 16
        done_base = n_done;
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            beat(3'(i + 1), 2'(i >> 1), 2'(i), 1'b0);
        end
        idle(1);
        check("ovf_done_cnt", n_done - done_base, 1);
        check("ovf_len16", prog_len, 5'd16);
        drain();

        // ---- 5-beat load with in_valid toggling
        done_base = n_done;
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            beat(3'(7 - i), 2'(i), 2'(3 - i), i == 4);
            cycle(1'b0, 1'b0, 3'b111, 2'b11, 2'b11, 1'b0);
        end
        check("toggle_done_cnt", n_done - done_base, 1);
        check("toggle_len5", prog_len, 5'd5);
        drain();

        // ---- restart after 2 beats; beat during load_start is dropped
        done_base = n_done;
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        beat(3'b011, 2'b01, 2'b01, 1'b0);
        beat(3'b101, 2'b10, 2'b01, 1'b0);
        cycle(1'b1, 1'b1, 3'b110, 2'b11, 2'b10, 1'b1);
        beat(3'b111, 2'b00, 2'b01, 1'b1);
        idle(1);
        check("restart_done_cnt", n_done - done_base, 1);
        check("restart_len1", prog_len, 5'd1);
        fetch_expect(4'd0, 7'h71);
        fetch_expect(4'd1, 7'h00);
        drain();

        // ---- 3-beat program, then reload drops core_run and masks fetch
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        beat(3'b110, 2'b10, 2'b01, 1'b0);
        beat(3'b101, 2'b01, 2'b10, 1'b0);
        beat(3'b011, 2'b11, 2'b11, 1'b1);
        idle(1);
        check("pre_reload_len3", prog_len, 5'd3);
        drain();
        cycle(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0);
        check("reload_core_run", core_run, 1'b0);
        drain();
        beat(3'b001, 2'b01, 2'b01, 1'b0);

        // ---- asynchronous reset mid-reload
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_core_run", core_run, 1'b0);
        check("mid_rst_load_done", load_done, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_prog_len", prog_len, 5'd0);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #0.1;
            check("mid_rst_fetch", fetch_instr, 7'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qpu_program_loader.md
# qpu_program_loader

Write-side counterpart of the QPU program ROM: accepts instruction fields (opcode, qubit1, qubit2) over a valid/ready stream, encodes them into the 7-bit instruction word the decoder consumes, and stores them in a 16-entry writable program memory. The PC reads the memory through a combinational fetch port, so the block is a drop-in replacement for the fixed ROM. A load state machine gates `core_run` so the core only executes a completely loaded program.

## Interface
Parameters:
- `DEPTH`, 16: program memory entries
- `AW`, 4: address width, equal to log2(DEPTH)
- `IW`, 7: instruction width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `load_start`  in  1  single-cycle pulse that begins or restarts a program load
- `in_valid`  in  1  instruction beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_opcode`  in  3  opcode field
- `in_q1`  in  2  qubit1 field
- `in_q2`  in  2  qubit2 field
- `in_last`  in  1  marks the final instruction of the program
- `load_done`  out  1  one-cycle pulse when a load completes
- `overflow`  out  1  sticky; program was truncated at DEPTH entries
- `prog_len`  out  AW+1  number of valid instructions, 0..16
- `core_run`  out  1  high while a complete program is resident
- `fetch_addr`  in  AW  PC address
- `fetch_instr`  out  IW  instruction at `fetch_addr`

## Operation
- Encoding: `instr = {opcode[2:0], q1[1:0], q2[1:0]}` (bits 6:4, 3:2, 1:0).
- States:
  - IDLE: after reset, nothing loaded.
  - LOAD: accepting beats.
  - READY: program resident.
- Transitions:
  - IDLE→LOAD on `load_start`.
  - LOAD→READY on an accepted beat with `in_last`, or on the accepted beat at `wr_ptr == DEPTH-1`.
  - READY→LOAD on `load_start`.
  - LOAD→LOAD on `load_start` (restart).
- Entering LOAD sets `wr_ptr` to 0, `prog_len` to 0 and `overflow` to 0.
- `in_ready = (state == LOAD) && !load_start`. A beat presented in the same cycle as `load_start` is not accepted.
- Each accepted beat writes `mem[wr_ptr]`, then increments `wr_ptr` and `prog_len`.
- Overflow: if the beat at address DEPTH-1 is accepted without `in_last`:
  - `overflow` is set.
  - The state goes to READY with `prog_len = 16`.
  - Further beats are not accepted (`in_ready` is low).
- `load_done` pulses on the LOAD→READY transition. It does not pulse on a restart.
- `core_run = (state == READY)`.
- `fetch_instr = (fetch_addr < prog_len) ? mem[fetch_addr] : 7'b0`. 7'b0 is the NOP encoding. Addresses outside the program are therefore safe for PC wrap-around.
- Memory contents are not reset. The `prog_len` masking makes stale data invisible.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 0
  - `load_done` 0
  - `overflow` 0
  - `prog_len` 0
  - `core_run` 0
  - `fetch_instr` 0 for any address
- Write latency: a beat accepted at edge N is visible on `fetch_instr` from after edge N, within the same cycle as the `prog_len` update.
- Fetch is combinational (0-cycle), matching the ROM it replaces.
- `load_start` in READY: `core_run` falls on the next edge. `fetch_instr` returns 0 from that edge onward, because `prog_len` is 0.
- Back-pressure: `in_valid` may be held across cycles while `in_ready` is low. Fields must stay stable until accepted.
- Reset mid-load: the block returns immediately to IDLE and the partially loaded program is discarded (`prog_len` 0).

## Structure
- `qpu_pkg` holds:
  - Opcode constants, `OPC_NOP = 3'b000`.
  - `IW`.
  - The `encode_instr(opcode, q1, q2)` function, shared with `instruction_decoder` so the field layout is defined once.
  - The loader state enum.
- One sub-module, `qpu_prog_mem`: DEPTH×IW array with a synchronous write port and an asynchronous read port.

## Test plan
- Reset, then sweep `fetch_addr` 0..15 → `fetch_instr` 0 everywhere, `core_run` 0, `in_ready` 0.
- `load_start`, then 3 beats (010/01/10, 001/00/11, 100/11/00, `in_last` on the third) → memory holds 0x26, 0x13, 0x4C; `prog_len` 3; one `load_done` pulse; `core_run` 1; `fetch_addr` 3 returns 0.
- 17 beats, none with `in_last` → 16 written, `overflow` 1, `prog_len` 16, `in_ready` 0 on the 17th beat, `core_run` 1.
- `in_valid` toggling every other cycle for a 5-beat load → exactly 5 writes, no duplicates, `prog_len` 5.
- `load_start` after 2 beats, then a new 1-beat program → `prog_len` 1, no `load_done` for the aborted load, the beat in the `load_start` cycle is not accepted.
- In READY with `prog_len` 3, pulse `load_start` → `core_run` drops the next cycle and all fetches return 0. Then assert `reset` mid-reload → IDLE, all outputs at reset values.
